// File: rtl/calc_serial_tx_pkg.sv
// Shared types and default sizing for the calculator serial transmitter.
// The frame is the result word followed by the flag nibble.
package calc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_FLAG_W  = 4;
  localparam int DEF_CLK_DIV = 4;

  function automatic int frame_w(input int width, input int flag_w);
    return width + flag_w;
  endfunction

  localparam int DEF_FRAME_W = frame_w(DEF_WIDTH, DEF_FLAG_W);

endpackage

// File: rtl/calc_serial_tx_if.sv
// SampleData/TxData/TxDone handshake between calculator control and the serial transmitter.
interface calc_serial_tx_if #(
  parameter int WIDTH  = 8,
  parameter int FLAG_W = 4
);
  logic              SampleData;
  logic              TxData;
  logic [WIDTH-1:0]  Result;
  logic [FLAG_W-1:0] Flag;
  logic              SerialOut;
  logic              TxClk;
  logic              TxDone;
  logic              TxBusy;

  modport master (
    output SampleData, TxData, Result, Flag,
    input  SerialOut, TxClk, TxDone, TxBusy
  );

  modport slave (
    input  SampleData, TxData, Result, Flag,
    output SerialOut, TxClk, TxDone, TxBusy
  );
endinterface

// File: rtl/calc_serial_tx_bit_timer.sv
// Bit-period divider: registered TxClk phase and an end-of-bit strobe.
module tx_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o,
  output logic txclk_o
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;

  always_comb begin
    bit_end_o = en_i && (div_q == LAST);
    div_d     = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (en_i) begin
      div_d = bit_end_o ? '0 : div_q + 1'b1;
    end
    // Phase tracks the next divider value so TxClk itself is a flop output.
    phase_d = (div_d >= HALF);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign txclk_o = phase_q;

endmodule

// File: rtl/calc_serial_tx.sv
// Calculator serial transmitter: latches {Result,Flag}, shifts it out MSB first
// with a divided bit clock, and answers TxData with a level TxDone.
module calc_serial_tx
  import calc_tx_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FLAG_W  = DEF_FLAG_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic             Clk,
  input logic             Reset,
  calc_serial_tx_if.slave bus
);
  localparam int FRAME_W = frame_w(WIDTH, FLAG_W);
  localparam int CNT_W   = $clog2(FRAME_W);

  tx_state_e           state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic                sout_q, sout_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                bit_end;
  logic                txclk;
  logic [FRAME_W-1:0]  sample_val;

  assign sample_val = {bus.Result, bus.Flag};

  tx_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .en_i      (state_q == SHIFT),
    .clr_i     (state_q != SHIFT),
    .bit_end_o (bit_end),
    .txclk_o   (txclk)
  );

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    sout_d   = sout_q;
    done_d   = done_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.SampleData) frame_d = sample_val;
        if (bus.TxData) begin
          state_d  = SHIFT;
          bitcnt_d = CNT_W'(FRAME_W - 1);
          busy_d   = 1'b1;
          // A same-edge sample must be the value that goes out.
          sout_d   = bus.SampleData ? sample_val[FRAME_W-1] : frame_q[FRAME_W-1];
        end
      end
      SHIFT: begin
        if (bit_end) begin
          if (bitcnt_q != '0) begin
            frame_d  = frame_q << 1;
            sout_d   = frame_q[FRAME_W-2];
            bitcnt_d = bitcnt_q - 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            sout_d  = 1'b0;
          end
        end
      end
      DONE: begin
        if (!bus.TxData) begin
          state_d = IDLE;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        sout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      bitcnt_q <= '0;
      sout_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      sout_q   <= sout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.SerialOut = sout_q;
  assign bus.TxClk     = txclk;
  assign bus.TxDone    = done_q;
  assign bus.TxBusy    = busy_q;

endmodule

// File: tb/tb_calc_serial_tx.sv
// Scoreboard bench for calc_serial_tx: expected frame bits are queued at start
// and popped on every TxClk rising edge.
module tb_calc_serial_tx;
  localparam int FW = 12;

  logic Clk;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   rises = 0;
  int   m;
  logic exp_q[$];

  calc_serial_tx_if #(.WIDTH(8), .FLAG_W(4)) bus ();

  calc_serial_tx #(.WIDTH(8), .FLAG_W(4), .CLK_DIV(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [FW-1:0] f);
    for (int i = FW - 1; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  // Receiver side: sample SerialOut at each TxClk rising edge.
  always @(posedge bus.TxClk) begin
    rises++;
    if (exp_q.size() == 0) chk("bit_extra", 1, 0);
    else chk("bit", {31'd0, bus.SerialOut}, {31'd0, exp_q.pop_front()});
  end

  // Counts negedges after start until TxDone, with optional mid-frame SampleData and TxData drop.
  task automatic run_wait(input int samp_at, input int drop_at, output int cnt);
    cnt = 0;
    do begin
      @(negedge Clk);
      cnt++;
      if (cnt == 1) chk("busy_start", {31'd0, bus.TxBusy}, 1);
      if (cnt == samp_at) begin
        bus.SampleData = 1'b1;
        bus.Result     = 8'hFF;
        bus.Flag       = 4'hF;
      end else begin
        bus.SampleData = 1'b0;
      end
      if (cnt == drop_at) bus.TxData = 1'b0;
    end while (!bus.TxDone && cnt < 200);
  endtask

  task automatic start(input logic [7:0] r, input logic [3:0] f, input logic smp);
    @(negedge Clk);
    bus.Result     = r;
    bus.Flag       = f;
    bus.SampleData = smp;
    bus.TxData     = 1'b1;
    rises          = 0;
  endtask

  task automatic end_handshake(input string tag);
    @(negedge Clk);
    bus.TxData = 1'b0;
    @(negedge Clk);
    chk({tag, "_done_fall"}, {31'd0, bus.TxDone}, 0);
    chk({tag, "_busy_fall"}, {31'd0, bus.TxBusy}, 0);
  endtask

  initial begin
    Reset          = 1'b1;
    bus.SampleData = 1'b0;
    bus.TxData     = 1'b0;
    bus.Result     = '0;
    bus.Flag       = '0;
    repeat (3) @(negedge Clk);
    chk("rst_sout", {31'd0, bus.SerialOut}, 0);
    chk("rst_txclk", {31'd0, bus.TxClk}, 0);
    chk("rst_done", {31'd0, bus.TxDone}, 0);
    chk("rst_busy", {31'd0, bus.TxBusy}, 0);
    Reset = 1'b0;

    // 6: no prior sample after reset sends zeros
    push_frame(12'h000);
    start(8'hAA, 4'hF, 1'b0);
    run_wait(0, 0, m);
    chk("t6_lat", m, 49);
    chk("t6_rises", rises, 12);
    end_handshake("t6");

    // 1: sample, then start; TxDone held while TxData high
    @(negedge Clk);
    bus.Result = 8'hA5; bus.Flag = 4'h3; bus.SampleData = 1'b1;
    push_frame({8'hA5, 4'h3});
    start(8'hA5, 4'h3, 1'b0);
    run_wait(0, 0, m);
    chk("t1_lat", m, 49);
    chk("t1_rises", rises, 12);
    repeat (3) @(negedge Clk);
    chk("t1_done_hold", {31'd0, bus.TxDone}, 1);
    end_handshake("t1");

    // 2: sample+start on one edge, mid-frame SampleData ignored
    push_frame({8'h5A, 4'hC});
    start(8'h5A, 4'hC, 1'b1);
    run_wait(14, 0, m);
    chk("t2_lat", m, 49);
    chk("t2_rises", rises, 12);
    end_handshake("t2");

    // 4: TxData dropped at bit 2; frame completes, TxDone for one cycle
    push_frame({8'h81, 4'h7});
    start(8'h81, 4'h7, 1'b1);
    run_wait(0, 10, m);
    chk("t4_lat", m, 49);
    chk("t4_rises", rises, 12);
    @(negedge Clk);
    chk("t4_done_1cyc", {31'd0, bus.TxDone}, 0);
    chk("t4_busy", {31'd0, bus.TxBusy}, 0);

    // 5: TxData held high; no second frame until handshake completes
    push_frame({8'h3C, 4'h5});
    start(8'h3C, 4'h5, 1'b1);
    run_wait(0, 0, m);
    chk("t5_lat", m, 49);
    repeat (20) @(negedge Clk);
    chk("t5_hold_done", {31'd0, bus.TxDone}, 1);
    chk("t5_hold_rises", rises, 12);
    end_handshake("t5");
    push_frame({8'hC3, 4'hA});
    start(8'hC3, 4'hA, 1'b1);
    run_wait(0, 0, m);
    chk("t5b_lat", m, 49);
    chk("t5b_rises", rises, 12);
    end_handshake("t5b");

    // 3: reset during bit 5 aborts immediately
    push_frame({8'hE7, 4'h9});
    start(8'hE7, 4'h9, 1'b1);
    @(negedge Clk);
    bus.SampleData = 1'b0;
    repeat (20) @(negedge Clk);
    bus.TxData = 1'b0;
    Reset = 1'b1;
    #1;
    chk("t3_sout", {31'd0, bus.SerialOut}, 0);
    chk("t3_txclk", {31'd0, bus.TxClk}, 0);
    chk("t3_busy", {31'd0, bus.TxBusy}, 0);
    chk("t3_done", {31'd0, bus.TxDone}, 0);
    chk("t3_sent", rises, 5);
    chk("t3_left", exp_q.size(), 7);
    exp_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (60) @(negedge Clk);
    chk("t3_no_done", {31'd0, bus.TxDone}, 0);
    push_frame({8'h96, 4'h1});
    start(8'h96, 4'h1, 1'b1);
    run_wait(0, 0, m);
    chk("t3b_lat", m, 49);
    chk("t3b_rises", rises, 12);
    end_handshake("t3b");
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_serial_tx.md
Name: calc_serial_tx

Overview:
Serial transmitter for the binary calculator datapath. It is the far end of the SampleData/TxData/TxDone handshake issued by the calculator control flow. SampleData latches the parallel result and flags. TxData starts an MSB-first serial frame with a divided bit clock. TxDone is returned as a level acknowledge. It sits between the ALU/memory result bus and the serial output pins.

Parameters:
WIDTH, 8, result bus width in bits
FLAG_W, 4, flag bus width in bits
CLK_DIV, 4, Clk cycles per serial bit; must be even and >= 2

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  reset
SampleData  in  1  latch Result/Flag into the frame register
TxData  in  1  transfer request; level, held until TxDone is seen
Result  in  WIDTH  calculator result / memory read data
Flag  in  FLAG_W  status flags appended after the result
SerialOut  out  1  serial data, MSB of {Result,Flag} first
TxClk  out  1  bit clock; receiver samples SerialOut on its rising edge
TxDone  out  1  frame-complete acknowledge (level)
TxBusy  out  1  high while in SHIFT or DONE

Behaviour:
- Reset is asynchronous and active-high; clock is Clk. While Reset is high: state=IDLE; frame register, bit counter and divider are 0; SerialOut, TxClk, TxDone and TxBusy are 0. Assertion mid-frame aborts the frame immediately, with no TxDone.
- The frame is FRAME_W = WIDTH+FLAG_W bits: {Result, Flag}.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - SampleData=1 at an edge loads the frame register with {Result, Flag}.
  - TxData=1 at an edge moves to SHIFT: bitcnt=FRAME_W-1, div=0, TxBusy=1, SerialOut=frame MSB.
  - SampleData and TxData high on the same edge: load and start together; the frame sent is the newly loaded value.
  - TxData with no prior SampleData sends the current register contents (all 0 after reset).
- SHIFT:
  - div counts 0..CLK_DIV-1. TxClk=0 for div<CLK_DIV/2 and 1 otherwise, so each bit gets one TxClk period with the rising edge mid-bit.
  - At div=CLK_DIV-1 with bitcnt>0: shift the frame left, SerialOut=next bit, bitcnt-1, div=0.
  - At div=CLK_DIV-1 with bitcnt=0: go to DONE, TxDone=1, TxClk=0, SerialOut=0.
  - SampleData is ignored, so the frame register is stable during transmission.
  - TxData deassertion is ignored; the frame always completes.
- DONE:
  - TxDone stays high while TxData=1.
  - On the first edge where TxData=0: TxDone=0, TxBusy=0, state=IDLE.
  - This is a four-phase handshake. TxDone low confirms the transmitter is ready, which the controller's sample states check for (!TxDone).
  - A new TxData request is accepted only from IDLE.
- Latency:
  - TxData sampled at edge N: the first bit is valid after edge N.
  - TxDone rises after edge N+FRAME_W*CLK_DIV.
  - TxDone falls one edge after TxData is sampled low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package calc_tx_pkg: state enum (IDLE, SHIFT, DONE), default WIDTH/FLAG_W/CLK_DIV constants, and the FRAME_W derivation.
- One sub-module, tx_bit_timer: CLK_DIV divider producing TxClk phase and a bit_end strobe, with enable and clear. The FSM and shift register stay in calc_serial_tx.

Test Plan:
All scenarios use WIDTH=8, FLAG_W=4, CLK_DIV=4, so FRAME_W=12 and a frame takes 48 cycles.
1. Result=8'hA5, Flag=4'h3, SampleData pulse, then TxData=1 -> SerialOut bits 1010_0101_0011 (one bit per 4 cycles); 12 TxClk rising edges; TxDone=1 48 cycles after start and held; TxData=0 -> TxDone and TxBusy fall one cycle later.
2. Load 8'h5A/4'hC, start, pulse SampleData with Result=8'hFF at bit 3 -> transmitted frame still 0101_1010_1100.
3. Reset pulsed during bit 5 -> SerialOut, TxClk, TxBusy and TxDone go 0 immediately, no TxDone; the next TxData sends from the MSB again.
4. TxData dropped at bit 2 -> all 12 bits still sent; TxDone high for exactly 1 cycle, then IDLE.
5. TxData held high continuously across two requests -> TxDone stays high and no second frame starts until TxData goes low, TxDone clears, and TxData rises again.
6. TxData after reset with no SampleData -> 12 zero bits, 12 TxClk pulses, TxDone after 48 cycles.
